pmod_in: RTL and testbench

Stereo I2S receiver for the PmodI2S2 line-in (ADC) path. It is the input counterpart to the synth's PmodI2S output stage. It acts as clock master: it derives MCLK, SCLK and LRCLK from the 100 MHz system clock, deserialises the ADC's serial data into 16-bit left/right samples, and presents each complete stereo frame with a one-cycle valid strobe to downstream synth/mixer logic.

---
 rtl/pmod_in.sv | 143 ++++++++++++++
 tb/tb_pmod_in.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pmod_in.sv
`default_nettype none
// pmod_in: I2S master receiver for the PmodI2S2 line-in path.
// Generates MCLK/SCLK/LRCLK and deserialises 16-bit stereo frames from sdin.
module pmod_in #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int MCLK_HALF = 25,
  parameter int SCLK_HALF = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdin,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid
);

  localparam int MCW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SCW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int PW  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  localparam logic [MCW-1:0] MCNT_MAX = MCW'(MCLK_HALF - 1);
  localparam logic [MCW-1:0] MCNT_ONE = MCW'(1);
  localparam logic [SCW-1:0] SCNT_MAX = SCW'(SCLK_HALF - 1);
  localparam logic [SCW-1:0] SCNT_ONE = SCW'(1);
  localparam logic [PW-1:0]  POS_LAST  = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0]  POS_FIRST = PW'(1);
  localparam logic [PW-1:0]  POS_WORD  = PW'(WIDTH);

  localparam logic [0:0] LEFT_SLOT  = 1'b0;
  localparam logic [0:0] RIGHT_SLOT = 1'b1;

  logic             r_sync1, r_sync2;
  logic [MCW-1:0]   r_mcnt;
  logic             r_mclk;
  logic [SCW-1:0]   r_scnt;
  logic             r_sclk;
  logic [PW-1:0]    r_pos;
  logic [0:0]       r_lrclk;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_left_hold;
  logic [WIDTH-1:0] r_left;
  logic [WIDTH-1:0] r_right;
  logic             r_valid;

  logic             w_sclk_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_capture;
  logic             w_word_done;
  logic [WIDTH-1:0] w_shift_next;

  assign w_sclk_tick  = (r_scnt == SCNT_MAX);
  assign w_rise       = w_sclk_tick & ~r_sclk;
  assign w_fall       = w_sclk_tick & r_sclk;
  assign w_capture    = w_rise && (r_pos >= POS_FIRST) && (r_pos <= POS_WORD);
  assign w_word_done  = w_rise && (r_pos == POS_WORD);
  // The word-completing bit is folded in here so it lands in the same cycle.
  assign w_shift_next = {r_shift[WIDTH-2:0], r_sync2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sdin;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt <= '0;
      r_mclk <= 1'b0;
    end else if (r_mcnt == MCNT_MAX) begin
      r_mcnt <= '0;
      r_mclk <= ~r_mclk;
    end else begin
      r_mcnt <= r_mcnt + MCNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scnt  <= '0;
      r_sclk  <= 1'b0;
      r_pos   <= '0;
      r_lrclk <= LEFT_SLOT;
    end else begin
      if (w_sclk_tick) begin
        r_scnt <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_scnt <= r_scnt + SCNT_ONE;
      end
      if (w_fall) begin
        if (r_pos == POS_LAST) begin
          r_pos   <= '0;
          r_lrclk <= ~r_lrclk;
        end else begin
          r_pos <= r_pos + POS_FIRST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_left_hold <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        r_shift <= w_shift_next;
      end
      // Left is parked until its right partner arrives so both outputs move together.
      if (w_word_done) begin
        if (r_lrclk == LEFT_SLOT) begin
          r_left_hold <= w_shift_next;
        end else if (r_lrclk == RIGHT_SLOT) begin
          r_right <= w_shift_next;
          r_left  <= r_left_hold;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign mclk  = r_mclk;
  assign sclk  = r_sclk;
  assign lrclk = r_lrclk[0];
  assign left  = r_left;
  assign right = r_right;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pmod_in.sv
`default_nettype none
// tb_pmod_in: directed self-checking bench for pmod_in with a behavioural I2S ADC model.
module tb_pmod_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sdin = 1'b0;
  logic        mclk, sclk, lrclk, valid;
  logic [15:0] left, right;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] fl [0:15];
  logic [15:0] fr [0:15];
  logic        pad = 1'b0;

  int          m_pos = 0;
  logic        m_lr = 1'b0;
  int          m_frame = 0;
  logic [15:0] m_word;

  pmod_in #(.WIDTH(16), .SLOT_BITS(32), .MCLK_HALF(25), .SCLK_HALF(50)) dut (
    .clk(clk), .rst_n(rst_n), .sdin(sdin),
    .mclk(mclk), .sclk(sclk), .lrclk(lrclk),
    .left(left), .right(right), .valid(valid)
  );

  always #5 clk = ~clk;

  // ADC model: changes sdin after each sclk falling edge, one-bit I2S delay, MSB first.
  always @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   = 0;
      m_lr    = 1'b0;
      m_frame = 0;
      sdin    = pad;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == 32) begin
        m_pos = 0;
        m_lr  = ~m_lr;
        if (!m_lr && m_frame < 15) m_frame = m_frame + 1;
      end
      m_word = m_lr ? fr[m_frame] : fl[m_frame];
      if (m_pos >= 1 && m_pos <= 16) sdin = m_word[16 - m_pos];
      else sdin = pad;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Waits for valid; n = negedges waited (-1 on timeout), changed = outputs moved
  // before valid, lr_rise = base+index of last lrclk rise seen (-1 if none).
  task automatic wait_valid(input int budget, input int base, output int n,
                            output bit changed, output int lr_rise);
    logic [15:0] l0, r0;
    logic        lr_prev;
    l0 = left; r0 = right; lr_prev = lrclk;
    changed = 1'b0; lr_rise = -1; n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (lrclk && !lr_prev) lr_rise = base + k;
      lr_prev = lrclk;
      if (valid) begin
        n = k;
        break;
      end
      if (left !== l0 || right !== r0) changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    int m1, m2, s1, s2;
    bit bad;
    logic mp, sp;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (mclk !== 1'b0) begin n_fail++; $display("FAIL reset_mclk got %b exp 0", mclk); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b exp 0", sclk); end
    n_checks++; if (lrclk !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk got %b exp 0", lrclk); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (left !== 16'h0) begin n_fail++; $display("FAIL reset_left got %h exp 0000", left); end
    n_checks++; if (right !== 16'h0) begin n_fail++; $display("FAIL reset_right got %h exp 0000", right); end
    #2 rst_n = 1'b1;
    m1 = -1; m2 = -1; s1 = -1; s2 = -1; bad = 1'b0; mp = 1'b0; sp = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (mclk && !mp) begin if (m1 < 0) m1 = k; else if (m2 < 0) m2 = k; end
      if (sclk && !sp) begin if (s1 < 0) s1 = k; else if (s2 < 0) s2 = k; end
      mp = mclk; sp = sclk;
      if (lrclk !== 1'b0 || valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (m1 != 25) begin n_fail++; $display("FAIL mclk_first_rise got %0d exp 25", m1); end
    n_checks++; if (m2 - m1 != 50) begin n_fail++; $display("FAIL mclk_period got %0d exp 50", m2 - m1); end
    n_checks++; if (s1 != 50) begin n_fail++; $display("FAIL sclk_first_rise got %0d exp 50", s1); end
    n_checks++; if (s2 - s1 != 100) begin n_fail++; $display("FAIL sclk_period got %0d exp 100", s2 - s1); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL early_lrclk_valid got activity exp none"); end
  endtask

  task automatic test_basic_frame();
    int n, lr1, lr2;
    bit ch;
    pad = 1'b0;
    fl[0] = 16'hA5C3; fr[0] = 16'h1234;
    fl[1] = 16'h5A5A; fr[1] = 16'h0F0F;
    do_reset();
    wait_valid(6000, 0, n, ch, lr1);
    n_checks++; if (n != 4850) begin n_fail++; $display("FAIL basic_first_valid got %0d exp 4850", n); end
    n_checks++; if (ch) begin n_fail++; $display("FAIL basic_pre_valid_outputs got changed exp 0"); end
    n_checks++; if (lr1 != 3200) begin n_fail++; $display("FAIL lrclk_first_rise got %0d exp 3200", lr1); end
    n_checks++; if (left !== 16'hA5C3) begin n_fail++; $display("FAIL basic_left got %h exp a5c3", left); end
    n_checks++; if (right !== 16'h1234) begin n_fail++; $display("FAIL basic_right got %h exp 1234", right); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width got %b exp 0", valid); end
    wait_valid(7000, 4851, n, ch, lr2);
    n_checks++; if (n + 1 != 6400) begin n_fail++; $display("FAIL basic_valid_gap got %0d exp 6400", n + 1); end
    n_checks++; if (ch) begin n_fail++; $display("FAIL basic_hold got changed exp held"); end
    n_checks++; if (lr2 - lr1 != 6400) begin n_fail++; $display("FAIL lrclk_period got %0d exp 6400", lr2 - lr1); end
    n_checks++; if (left !== 16'h5A5A) begin n_fail++; $display("FAIL basic2_left got %h exp 5a5a", left); end
    n_checks++; if (right !== 16'h0F0F) begin n_fail++; $display("FAIL basic2_right got %h exp 0f0f", right); end
  endtask

  task automatic test_padding();
    int n, lr;
    bit ch;
    pad = 1'b1;
    fl[0] = 16'h0000; fr[0] = 16'h0001;
    do_reset();
    wait_valid(6000, 0, n, ch, lr);
    n_checks++; if (n != 4850) begin n_fail++; $display("FAIL pad_valid got %0d exp 4850", n); end
    n_checks++; if (left !== 16'h0000) begin n_fail++; $display("FAIL pad_left got %h exp 0000", left); end
    n_checks++; if (right !== 16'h0001) begin n_fail++; $display("FAIL pad_right got %h exp 0001", right); end
    pad = 1'b0;
  endtask

  task automatic test_extremes();
    int n, lr;
    bit ch;
    pad = 1'b0;
    fl[0] = 16'h8000; fr[0] = 16'h7FFF;
    fl[1] = 16'hFFFF; fr[1] = 16'h0000;
    do_reset();
    wait_valid(6000, 0, n, ch, lr);
    n_checks++; if (left !== 16'h8000 || right !== 16'h7FFF) begin
      n_fail++; $display("FAIL extreme1 got %h/%h exp 8000/7fff", left, right); end
    @(negedge clk);
    wait_valid(7000, 0, n, ch, lr);
    n_checks++; if (n + 1 != 6400) begin n_fail++; $display("FAIL extreme_gap got %0d exp 6400", n + 1); end
    n_checks++; if (left !== 16'hFFFF || right !== 16'h0000) begin
      n_fail++; $display("FAIL extreme2 got %h/%h exp ffff/0000", left, right); end
  endtask

  task automatic test_reset_mid_frame();
    int n, lr;
    bit ch, bad;
    fl[0] = 16'hDEAD; fr[0] = 16'hBEEF;
    do_reset();
    repeat (4220) @(negedge clk);
    n_checks++; if (lrclk !== 1'b1) begin n_fail++; $display("FAIL mid_in_right_slot got %b exp 1", lrclk); end
    rst_n = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid !== 1'b0 || left !== 16'h0 || right !== 16'h0 || sclk !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL mid_reset_hold got activity exp all zero"); end
    fl[0] = 16'h1111; fr[0] = 16'h2222;
    #2 rst_n = 1'b1;
    wait_valid(6000, 0, n, ch, lr);
    n_checks++; if (n != 4850) begin n_fail++; $display("FAIL mid_first_valid got %0d exp 4850", n); end
    n_checks++; if (ch) begin n_fail++; $display("FAIL mid_outputs_before_valid got changed exp 0"); end
    n_checks++; if (left !== 16'h1111 || right !== 16'h2222) begin
      n_fail++; $display("FAIL mid_values got %h/%h exp 1111/2222", left, right); end
  endtask

  task automatic test_streaming();
    int n, lr;
    bit ch;
    pad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_valid(7000, 0, n, ch, lr);
      n_checks++; if (n != ((i == 0) ? 4850 : 6399)) begin
        n_fail++; $display("FAIL stream_timing[%0d] got %0d exp %0d", i, n, (i == 0) ? 4850 : 6399); end
      n_checks++; if (left !== fl[i] || right !== fr[i]) begin
        n_fail++; $display("FAIL stream_data[%0d] got %h/%h exp %h/%h", i, left, right, fl[i], fr[i]); end
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup[%0d] got %b exp 0", i, valid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      fl[i] = 16'h0;
      fr[i] = 16'h0;
    end
    #1;
    test_reset();
    test_basic_frame();
    test_padding();
    test_extremes();
    test_reset_mid_frame();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
